// File: rtl/jt89_pkg.sv
// Shared constants for the SN76489 register interface: latch indices, volume off level,
// busy counter sizing and the tone period merge helper.
package jt89_pkg;

  localparam logic [2:0] L_TONE0 = 3'b000;
  localparam logic [2:0] L_VOL0  = 3'b001;
  localparam logic [2:0] L_TONE1 = 3'b010;
  localparam logic [2:0] L_VOL1  = 3'b011;
  localparam logic [2:0] L_TONE2 = 3'b100;
  localparam logic [2:0] L_VOL2  = 3'b101;
  localparam logic [2:0] L_NOISE = 3'b110;
  localparam logic [2:0] L_VOL3  = 3'b111;

  localparam logic [3:0] VOL_OFF = 4'hF;

  localparam int RDY_W = 8;
  localparam logic [RDY_W-1:0] RDY_ZERO = {RDY_W{1'b0}};
  localparam logic [RDY_W-1:0] RDY_ONE  = {{(RDY_W-1){1'b0}}, 1'b1};

  // A latch byte replaces the low nibble of a period, a data byte the upper six bits.
  function automatic logic [9:0] tone_merge(input logic [9:0] period, input logic [7:0] data);
    logic [9:0] merged;
    if (data[7]) begin
      merged = {period[9:4], data[3:0]};
    end else begin
      merged = {data[5:0], period[3:0]};
    end
    return merged;
  endfunction

endpackage

// File: rtl/jt89_ready_cnt.sv
// READY wait line: an accepted write drops READY and loads the busy counter, which then
// counts clk_en pulses down to zero before READY returns high.
module jt89_ready_cnt
  import jt89_pkg::*;
#(
  parameter int READY_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic evt,
  output logic accept,
  output logic ready
);

  localparam logic [RDY_W-1:0] LOAD = RDY_W'(READY_CYCLES);

  logic [RDY_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  assign accept = evt & ready_q;
  assign ready  = ready_q;

  // Expiry (count already at zero while busy) takes one more clk to raise READY, so an
  // event landing on that clk still sees ready_q low and is dropped.
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (accept) begin
      ready_d = 1'b0;
      cnt_d   = LOAD;
    end else if (!ready_q) begin
      if (cnt_q == RDY_ZERO) begin
        ready_d = 1'b1;
      end else if (clk_en) begin
        cnt_d = cnt_q - RDY_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and READY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= RDY_ZERO;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/jt89_regs.sv
// jt89_regs: SN76489 CPU write decoder and register file with READY handshake.
// Define JT89_GG_STEREO_EN to add the Game Gear stereo port (gg_wr / gg_pan).
module jt89_regs
  import jt89_pkg::*;
#(
  parameter int READY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
`ifdef JT89_GG_STEREO_EN
  input  logic       gg_wr,
  output logic [7:0] gg_pan,
`endif
  output logic       clr
);

  logic       wr_prev_q, wr_prev_d;
  logic       wr_evt_s, accept_s;
  logic [2:0] latch_q, latch_d, tgt_s;
  logic [9:0] tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
  logic [3:0] vol0_q, vol0_d, vol1_q, vol1_d, vol2_q, vol2_d, vol3_q, vol3_d;
  logic [2:0] ctrl3_q, ctrl3_d;
  logic       clr_q, clr_d;

  assign wr_evt_s = wr_prev_q & ~(cs_n | wr_n);

  jt89_ready_cnt #(
    .READY_CYCLES (READY_CYCLES)
  ) u_ready (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .evt    (wr_evt_s),
    .accept (accept_s),
    .ready  (ready)
  );

  // Latch bytes route by their own index, data bytes by the stored one.
  always_comb begin
    wr_prev_d = cs_n | wr_n;
    latch_d   = latch_q;
    tone0_d   = tone0_q;
    tone1_d   = tone1_q;
    tone2_d   = tone2_q;
    vol0_d    = vol0_q;
    vol1_d    = vol1_q;
    vol2_d    = vol2_q;
    vol3_d    = vol3_q;
    ctrl3_d   = ctrl3_q;
    clr_d     = 1'b0;
    tgt_s     = din[7] ? din[6:4] : latch_q;
    if (accept_s) begin
      if (din[7]) begin
        latch_d = din[6:4];
      end else begin
        latch_d = latch_q;
      end
      case (tgt_s)
        L_TONE0: tone0_d = tone_merge(tone0_q, din);
        L_TONE1: tone1_d = tone_merge(tone1_q, din);
        L_TONE2: tone2_d = tone_merge(tone2_q, din);
        L_VOL0:  vol0_d  = din[3:0];
        L_VOL1:  vol1_d  = din[3:0];
        L_VOL2:  vol2_d  = din[3:0];
        L_VOL3:  vol3_d  = din[3:0];
        L_NOISE: begin
          ctrl3_d = din[2:0];
          clr_d   = 1'b1;
        end
        default: begin
          clr_d = 1'b0;
        end
      endcase
    end else begin
      latch_d = latch_q;
    end
  end

  // PSG register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q <= 1'b1;
      latch_q   <= L_TONE0;
      tone0_q   <= 10'd0;
      tone1_q   <= 10'd0;
      tone2_q   <= 10'd0;
      vol0_q    <= VOL_OFF;
      vol1_q    <= VOL_OFF;
      vol2_q    <= VOL_OFF;
      vol3_q    <= VOL_OFF;
      ctrl3_q   <= 3'd0;
      clr_q     <= 1'b0;
    end else begin
      wr_prev_q <= wr_prev_d;
      latch_q   <= latch_d;
      tone0_q   <= tone0_d;
      tone1_q   <= tone1_d;
      tone2_q   <= tone2_d;
      vol0_q    <= vol0_d;
      vol1_q    <= vol1_d;
      vol2_q    <= vol2_d;
      vol3_q    <= vol3_d;
      ctrl3_q   <= ctrl3_d;
      clr_q     <= clr_d;
    end
  end

  assign tone0 = tone0_q;
  assign tone1 = tone1_q;
  assign tone2 = tone2_q;
  assign vol0  = vol0_q;
  assign vol1  = vol1_q;
  assign vol2  = vol2_q;
  assign vol3  = vol3_q;
  assign ctrl3 = ctrl3_q;
  assign clr   = clr_q;

`ifdef JT89_GG_STEREO_EN
  logic       gg_prev_q, gg_prev_d;
  logic [7:0] gg_pan_q, gg_pan_d;

  // The stereo port bypasses READY entirely.
  always_comb begin
    gg_prev_d = gg_wr;
    if (gg_wr && !gg_prev_q) begin
      gg_pan_d = din;
    end else begin
      gg_pan_d = gg_pan_q;
    end
  end

  // Stereo enable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gg_prev_q <= 1'b0;
      gg_pan_q  <= 8'hFF;
    end else begin
      gg_prev_q <= gg_prev_d;
      gg_pan_q  <= gg_pan_d;
    end
  end

  assign gg_pan = gg_pan_q;
`endif

endmodule
